layer_serializer: RTL and testbench

Sequencing stage between two fully-connected layers. Captures the parallel output vector of a layer (NN neurons, all completing in the same cycle) and replays it as a serial `x_in`/`x_valid` stream to the next layer, one neuron value per accepted beat, neuron 0 first. Downstream backpressure is supported, and overruns and misaligned neuron completions are flagged.

---
 rtl/layer_serializer.sv | 135 +++++++++++++
 tb/tb_layer_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/layer_serializer.sv
// Captures a layer's parallel neuron outputs and replays them as a serial
// valid/ready stream, neuron 0 first, flagging dropped and misaligned captures.
module layer_serializer #(
   parameter int NN        = 30,
   parameter int dataWidth = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NN-1:0]             i_valid,
   input  logic [NN*dataWidth-1:0]   i_data,
   output logic [dataWidth-1:0]      o_data,
   output logic                      o_valid,
   input  logic                      o_ready,
   output logic                      o_last,
   output logic                      busy,
   input  logic                      clr_err,
   output logic                      err_overrun,
   output logic                      err_mismatch
);

   localparam int IDX_W = $clog2(NN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                   state_r, state_s;
   logic [IDX_W-1:0]         idx_r, idx_s;
   logic [NN*dataWidth-1:0]  cap_r, cap_s;
   logic [dataWidth-1:0]     o_data_r, word_s;
   logic                     o_valid_r, o_last_r;
   logic                     err_ovr_r, err_ovr_s;
   logic                     err_mis_r, err_mis_s;
   logic                     trigger_s, accept_s, ovr_set_s, mis_set_s;

   // Next-state, capture and index sequencing
   always_comb begin
      trigger_s = i_valid[0];
      accept_s  = o_valid_r & o_ready;
      state_s   = state_r;
      idx_s     = idx_r;
      cap_s     = cap_r;
      ovr_set_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (trigger_s) begin
               cap_s   = i_data;
               idx_s   = {IDX_W{1'b0}};
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (accept_s && (idx_r != IDX_LAST)) begin
               idx_s     = idx_r + IDX_W'(1);
               ovr_set_s = trigger_s;
            end else if (accept_s && trigger_s) begin
               // Last beat accepted together with a new vector: no bubble
               cap_s = i_data;
               idx_s = {IDX_W{1'b0}};
            end else if (accept_s) begin
               state_s = IDLE;
               idx_s   = {IDX_W{1'b0}};
            end else begin
               ovr_set_s = trigger_s;
            end
         end
         default: begin
            state_s = IDLE;
            idx_s   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Select the word the output register will present next
   always_comb begin
      word_s = {dataWidth{1'b0}};
      for (int n = 0; n < NN; n++) begin
         word_s = word_s | (cap_s[n*dataWidth +: dataWidth] & {dataWidth{idx_s == IDX_W'(n)}});
      end
   end

   // Sticky error flags: a new event wins over a clear in the same cycle
   always_comb begin
      mis_set_s = trigger_s & (i_valid != {NN{1'b1}});
      if (ovr_set_s) begin
         err_ovr_s = 1'b1;
      end else if (clr_err) begin
         err_ovr_s = 1'b0;
      end else begin
         err_ovr_s = err_ovr_r;
      end
      if (mis_set_s) begin
         err_mis_s = 1'b1;
      end else if (clr_err) begin
         err_mis_s = 1'b0;
      end else begin
         err_mis_s = err_mis_r;
      end
   end

   // State, capture register and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         idx_r     <= {IDX_W{1'b0}};
         cap_r     <= {(NN*dataWidth){1'b0}};
         o_data_r  <= {dataWidth{1'b0}};
         o_valid_r <= 1'b0;
         o_last_r  <= 1'b0;
         err_ovr_r <= 1'b0;
         err_mis_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         cap_r     <= cap_s;
         o_data_r  <= (state_s == SHIFT) ? word_s : {dataWidth{1'b0}};
         o_valid_r <= (state_s == SHIFT);
         o_last_r  <= (state_s == SHIFT) && (idx_s == IDX_LAST);
         err_ovr_r <= err_ovr_s;
         err_mis_r <= err_mis_s;
      end
   end

   assign o_data       = o_data_r;
   assign o_valid      = o_valid_r;
   assign o_last       = o_last_r;
   assign busy         = o_valid_r;
   assign err_overrun  = err_ovr_r;
   assign err_mismatch = err_mis_r;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed plus randomized bench for layer_serializer with a queue-based
// reference model of the pending beats and sticky error flags.
module tb_layer_serializer;

   localparam int NN = 4;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NN-1:0]     i_valid = '0;
   logic [NN*DW-1:0]  i_data = '0;
   logic [DW-1:0]     o_data;
   logic              o_valid;
   logic              o_ready = 1'b1;
   logic              o_last;
   logic              busy;
   logic              clr_err = 1'b0;
   logic              err_overrun;
   logic              err_mismatch;

   int checks   = 0;
   int failures = 0;
   int vcount   = 0;

   logic [DW-1:0] q[$];
   logic          m_ovr = 1'b0;
   logic          m_mis = 1'b0;

   localparam logic [NN*DW-1:0] VEC1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
   localparam logic [NN*DW-1:0] VEC2 = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
   localparam logic [NN*DW-1:0] VEC3 = {16'h000D, 16'h000C, 16'h000B, 16'h000A};

   layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
      .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
      .busy(busy), .clr_err(clr_err), .err_overrun(err_overrun),
      .err_mismatch(err_mismatch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Beats still owed downstream live in q; the front one is on the wire.
   task automatic model_step(input logic [NN-1:0] v, input logic [NN*DW-1:0] d,
                             input logic rdy, input logic clr);
      logic set_ovr, set_mis;
      set_ovr = 1'b0;
      set_mis = v[0] && (v != '1);
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (v[0]) begin
         if (q.size() == 0) begin
            for (int n = 0; n < NN; n++) q.push_back(d[n*DW +: DW]);
         end else begin
            set_ovr = 1'b1;
         end
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (set_mis) m_mis = 1'b1;
      else if (clr) m_mis = 1'b0;
   endtask

   task automatic check_outputs();
      logic ev;
      ev = (q.size() != 0);
      chk("o_valid", 32'(o_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(ev));
      chk("o_last", 32'(o_last), 32'(q.size() == 1));
      if (ev) chk("o_data", 32'(o_data), 32'(q[0]));
      chk("err_overrun", 32'(err_overrun), 32'(m_ovr));
      chk("err_mismatch", 32'(err_mismatch), 32'(m_mis));
      if (o_valid) vcount++;
   endtask

   task automatic cycle(input logic [NN-1:0] v, input logic [NN*DW-1:0] d,
                        input logic rdy, input logic clr);
      i_valid = v;
      i_data  = d;
      o_ready = rdy;
      clr_err = clr;
      @(posedge clk);
      model_step(v, d, rdy, clr);
      #1;
      check_outputs();
      i_valid = '0;
      clr_err = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_data", 32'(o_data), 32'd0);
      chk("rst_o_last", 32'(o_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_overrun", 32'(err_overrun), 32'd0);
      chk("rst_err_mismatch", 32'(err_mismatch), 32'd0);
      rst = 1'b1;

      // Basic
      cycle(4'b1111, VEC1, 1'b1, 1'b0);
      chk("basic_first", 32'(o_data), 32'h1);
      repeat (5) cycle('0, '0, 1'b1, 1'b0);

      // Backpressure: stall while 2 is on the wire
      vcount = 0;
      cycle(4'b1111, VEC1, 1'b1, 1'b0);
      cycle('0, '0, 1'b1, 1'b0);
      repeat (3) cycle('0, '0, 1'b0, 1'b0);
      repeat (4) cycle('0, '0, 1'b1, 1'b0);
      chk("bp_valid_cycles", 32'(vcount), 32'd7);

      // Back-to-back: new trigger as beat 4 is accepted
      vcount = 0;
      cycle(4'b1111, VEC1, 1'b1, 1'b0);
      repeat (3) cycle('0, '0, 1'b1, 1'b0);
      cycle(4'b1111, VEC2, 1'b1, 1'b0);
      chk("b2b_first", 32'(o_data), 32'h5);
      repeat (4) cycle('0, '0, 1'b1, 1'b0);
      chk("b2b_valid_cycles", 32'(vcount), 32'd8);

      // Overrun: trigger while 2 is being sent
      cycle(4'b1111, VEC1, 1'b1, 1'b0);
      cycle('0, '0, 1'b1, 1'b0);
      cycle(4'b1111, VEC2, 1'b1, 1'b0);
      chk("ovr_set", 32'(err_overrun), 32'd1);
      chk("ovr_continue", 32'(o_data), 32'h3);
      repeat (4) cycle('0, '0, 1'b1, 1'b0);
      cycle('0, '0, 1'b1, 1'b1);
      chk("ovr_cleared", 32'(err_overrun), 32'd0);

      // Mismatch capture still proceeds; bit 0 low means no trigger
      cycle(4'b0101, VEC3, 1'b1, 1'b0);
      chk("mis_set", 32'(err_mismatch), 32'd1);
      repeat (4) cycle('0, '0, 1'b1, 1'b0);
      cycle('0, '0, 1'b1, 1'b1);
      cycle(4'b1110, VEC2, 1'b1, 1'b0);
      chk("no_trig_valid", 32'(o_valid), 32'd0);
      chk("no_trig_flag", 32'(err_mismatch), 32'd0);

      // Reset mid-vector, asserted between clock edges
      cycle(4'b1111, VEC1, 1'b1, 1'b0);
      cycle('0, '0, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("arst_o_valid", 32'(o_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_o_last", 32'(o_last), 32'd0);
      chk("arst_o_data", 32'(o_data), 32'd0);
      q.delete();
      m_ovr = 1'b0;
      m_mis = 1'b0;
      #1 rst = 1'b1;
      cycle(4'b1111, VEC2, 1'b1, 1'b0);
      chk("post_rst_first", 32'(o_data), 32'h5);
      repeat (4) cycle('0, '0, 1'b1, 1'b0);

      // Randomized traffic against the model
      repeat (400) begin
         logic [NN-1:0]    v;
         logic [NN*DW-1:0] d;
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 2) v = NN'($urandom);
         else if (r < 4) v = '1;
         else v = '0;
         d = {$urandom, $urandom};
         cycle(v, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
